burst_sequencer: RTL and testbench

- Control stage directly upstream of the AXI burst copy engine.
- Takes a multi-burst copy command from the register bank: source base, destination base, burst length, burst count and coherency flags.
- Drives the engine's enable/ready handshake once per burst and advances both addresses by one burst stride each time.
- Reports busy/done/abort/error status and a cycle count, used for memory-ordering and coherency benchmarking.

---
 rtl/burst_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_burst_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_sequencer.sv
// Burst sequencer: turns one multi-burst copy command into a series of single-burst
// enable/ready handshakes with the AXI copy engine and reports status and cycle count.
module burst_sequencer #(
    parameter int C_registers_DATA_WIDTH = 32,
    parameter int C_data_DATA_WIDTH      = 32,
    parameter int MAX_BURST              = 256
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              start,
    input  logic                              abort,
    input  logic [C_registers_DATA_WIDTH-1:0] src_address,
    input  logic [C_registers_DATA_WIDTH-1:0] dst_address,
    input  logic [C_registers_DATA_WIDTH-1:0] burst_length,
    input  logic [C_registers_DATA_WIDTH-1:0] burst_count,
    input  logic [C_registers_DATA_WIDTH-1:0] read_coherency_flag,
    input  logic [C_registers_DATA_WIDTH-1:0] write_coherency_flag,
    input  logic                              read_ready,
    input  logic                              write_ready,
    output logic                              enable,
    output logic [C_registers_DATA_WIDTH-1:0] read_address_con,
    output logic [C_registers_DATA_WIDTH-1:0] write_address_con,
    output logic [C_registers_DATA_WIDTH-1:0] burst_length_con,
    output logic [C_registers_DATA_WIDTH-1:0] read_coherency_flag_con,
    output logic [C_registers_DATA_WIDTH-1:0] write_coherency_flag_con,
    output logic                              busy,
    output logic                              done,
    output logic                              aborted,
    output logic                              config_error,
    output logic [C_registers_DATA_WIDTH-1:0] bursts_done,
    output logic [C_registers_DATA_WIDTH-1:0] cycle_count
);

    localparam int W = C_registers_DATA_WIDTH;
    localparam logic [W-1:0] BYTES_PER_BEAT = W'(C_data_DATA_WIDTH / 8);
    localparam logic [W-1:0] MAX_LEN        = W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DRAIN} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic           r_startPrev;
    logic           r_abortPending;
    logic           r_drainSeen;
    logic [W-1:0]   r_burstCount;
    logic [W-1:0]   w_stride;
    logic           w_accept;
    logic           w_reject;
    logic           w_goRun;
    logic           w_burstEnd;
    logic           w_finish;
    logic           w_advance;

    assign w_stride = burst_length_con * BYTES_PER_BEAT;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // DRAIN needs a prior DRAIN cycle before leaving, so enable stays low >= 2 cycles.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_goRun     = 1'b0;
        w_burstEnd  = 1'b0;
        w_finish    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !r_startPrev) begin
                    w_accept    = 1'b1;
                    w_nextState = CHECK;
                end
            end
            CHECK: begin
                if ((burst_length_con == '0) || (burst_length_con > MAX_LEN) ||
                    (r_burstCount == '0)) begin
                    w_reject    = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_goRun     = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (read_ready && write_ready) begin
                    w_burstEnd  = 1'b1;
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drainSeen && !read_ready && !write_ready) begin
                    if ((bursts_done == r_burstCount) || r_abortPending) begin
                        w_finish    = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_advance   = 1'b1;
                        w_goRun     = 1'b1;
                        w_nextState = RUN;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_startPrev              <= 1'b0;
            r_abortPending           <= 1'b0;
            r_drainSeen              <= 1'b0;
            r_burstCount             <= '0;
            enable                   <= 1'b0;
            read_address_con         <= '0;
            write_address_con        <= '0;
            burst_length_con         <= '0;
            read_coherency_flag_con  <= '0;
            write_coherency_flag_con <= '0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
            aborted                  <= 1'b0;
            config_error             <= 1'b0;
            bursts_done              <= '0;
            cycle_count              <= '0;
        end else begin
            r_startPrev <= start;
            r_drainSeen <= (r_state == DRAIN);

            if (w_accept) begin
                read_address_con         <= src_address;
                write_address_con        <= dst_address;
                burst_length_con         <= burst_length;
                r_burstCount             <= burst_count;
                read_coherency_flag_con  <= read_coherency_flag;
                write_coherency_flag_con <= write_coherency_flag;
                done                     <= 1'b0;
                aborted                  <= 1'b0;
                config_error             <= 1'b0;
                bursts_done              <= '0;
                busy                     <= 1'b1;
                r_abortPending           <= 1'b0;
                // The accepting cycle is counted as the first busy cycle.
                cycle_count              <= W'(1);
            end else if (busy && (cycle_count != '1)) begin
                cycle_count <= cycle_count + W'(1);
            end

            if (w_reject) begin
                config_error <= 1'b1;
                done         <= 1'b1;
                busy         <= 1'b0;
            end

            if (w_goRun) begin
                enable <= 1'b1;
            end

            if (w_burstEnd) begin
                enable      <= 1'b0;
                bursts_done <= bursts_done + W'(1);
            end

            if (w_advance) begin
                read_address_con  <= read_address_con + w_stride;
                write_address_con <= write_address_con + w_stride;
            end

            if (w_finish) begin
                done           <= 1'b1;
                aborted        <= r_abortPending;
                busy           <= 1'b0;
                r_abortPending <= 1'b0;
            end else if (abort && busy && !w_reject) begin
                r_abortPending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed testbench for burst_sequencer with a simple enable/ready engine model
// that also logs the addresses presented at each burst start.
module tb_burst_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_address = '0;
    logic [31:0] dst_address = '0;
    logic [31:0] burst_length = '0;
    logic [31:0] burst_count = '0;
    logic [31:0] read_coherency_flag = '0;
    logic [31:0] write_coherency_flag = '0;
    logic        read_ready = 1'b0;
    logic        write_ready = 1'b0;
    logic        enable;
    logic [31:0] read_address_con;
    logic [31:0] write_address_con;
    logic [31:0] burst_length_con;
    logic [31:0] read_coherency_flag_con;
    logic [31:0] write_coherency_flag_con;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        config_error;
    logic [31:0] bursts_done;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;
    int riseCount = 0;
    int lowCount = 100;
    int engCnt = 0;
    int engDelay = 10;
    int engSkew = 0;
    logic prevEnable = 1'b0;
    logic [31:0] rdLog[$];
    logic [31:0] wrLog[$];

    burst_sequencer #(
        .C_registers_DATA_WIDTH(32),
        .C_data_DATA_WIDTH(32),
        .MAX_BURST(256)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .start(start),
        .abort(abort),
        .src_address(src_address),
        .dst_address(dst_address),
        .burst_length(burst_length),
        .burst_count(burst_count),
        .read_coherency_flag(read_coherency_flag),
        .write_coherency_flag(write_coherency_flag),
        .read_ready(read_ready),
        .write_ready(write_ready),
        .enable(enable),
        .read_address_con(read_address_con),
        .write_address_con(write_address_con),
        .burst_length_con(burst_length_con),
        .read_coherency_flag_con(read_coherency_flag_con),
        .write_coherency_flag_con(write_coherency_flag_con),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .config_error(config_error),
        .bursts_done(bursts_done),
        .cycle_count(cycle_count)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Engine model: readies rise engDelay cycles after enable (read side engSkew earlier)
    // and drop once enable falls; each enable rise logs the addresses and gap length.
    always @(negedge aclk) begin
        if (enable && !prevEnable) begin
            riseCount++;
            rdLog.push_back(read_address_con);
            wrLog.push_back(write_address_con);
            checkOutput("readiesLowAtEnableRise", {30'b0, read_ready, write_ready}, 32'd0);
            checkOutput("enableLowGapAtLeast2", {31'b0, (lowCount >= 2)}, 32'd1);
        end
        if (enable) lowCount = 0;
        else lowCount++;
        prevEnable = enable;
        if (enable) begin
            engCnt++;
            if (engCnt >= engDelay - engSkew) read_ready = 1'b1;
            if (engCnt >= engDelay) write_ready = 1'b1;
        end else begin
            engCnt = 0;
            read_ready = 1'b0;
            write_ready = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                 input logic [31:0] len, input logic [31:0] cnt,
                                 input bit holdStart);
        @(negedge aclk);
        src_address = src;
        dst_address = dst;
        burst_length = len;
        burst_count = cnt;
        read_coherency_flag = 32'h0000_0003;
        write_coherency_flag = 32'h0000_000C;
        start = 1'b1;
        @(negedge aclk);
        if (!holdStart) start = 1'b0;
        src_address = ~src;
        dst_address = ~dst;
        burst_length = 32'd999;
        burst_count = 32'd0;
        read_coherency_flag = 32'hFFFF_FFFF;
        write_coherency_flag = 32'hFFFF_FFFF;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        checkOutput(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic waitRises(input int target, input string tag);
        int n = 0;
        while (riseCount < target && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        checkOutput(tag, {31'b0, (riseCount >= target)}, 32'd1);
    endtask

    initial begin
        int base;
        logic [31:0] expRd[3];
        logic [31:0] expWr[3];

        repeat (3) @(negedge aclk);
        checkOutput("resetEnable", {31'b0, enable}, 32'd0);
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetDone", {31'b0, done}, 32'd0);
        checkOutput("resetCycleCount", cycle_count, 32'd0);
        checkOutput("resetReadAddr", read_address_con, 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        $display("[TB] single burst");
        engSkew = 0;
        base = riseCount;
        applyStimulus(32'h1000, 32'h2000, 32'd4, 32'd1, 1'b0);
        checkOutput("t1Busy", {31'b0, busy}, 32'd1);
        waitIdle("t1IdleTimeout");
        checkOutput("t1Done", {31'b0, done}, 32'd1);
        checkOutput("t1BurstsDone", bursts_done, 32'd1);
        checkOutput("t1Aborted", {31'b0, aborted}, 32'd0);
        checkOutput("t1ConfigError", {31'b0, config_error}, 32'd0);
        checkOutput("t1Rises", riseCount - base, 32'd1);
        checkOutput("t1ReadAddr", read_address_con, 32'h1000);
        checkOutput("t1WriteAddr", write_address_con, 32'h2000);
        checkOutput("t1LenCon", burst_length_con, 32'd4);
        checkOutput("t1RdFlag", read_coherency_flag_con, 32'h3);
        checkOutput("t1WrFlag", write_coherency_flag_con, 32'hC);

        $display("[TB] three bursts with skewed readies");
        engSkew = 4;
        rdLog.delete();
        wrLog.delete();
        applyStimulus(32'h1000, 32'h8000, 32'd16, 32'd3, 1'b0);
        waitIdle("t2IdleTimeout");
        while (rdLog.size() < 3) rdLog.push_back(32'hFFFF_FFFF);
        while (wrLog.size() < 3) wrLog.push_back(32'hFFFF_FFFF);
        expRd = '{32'h1000, 32'h1040, 32'h1080};
        expWr = '{32'h8000, 32'h8040, 32'h8080};
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t2ReadAddr%0d", i), rdLog[i], expRd[i]);
            checkOutput($sformatf("t2WriteAddr%0d", i), wrLog[i], expWr[i]);
        end
        checkOutput("t2BurstCountLog", rdLog.size(), 32'd3);
        checkOutput("t2BurstsDone", bursts_done, 32'd3);
        checkOutput("t2Done", {31'b0, done}, 32'd1);
        engSkew = 0;

        $display("[TB] rejected commands");
        base = riseCount;
        applyStimulus(32'h1000, 32'h2000, 32'd0, 32'd1, 1'b0);
        waitIdle("t3aIdleTimeout");
        checkOutput("t3aConfigError", {31'b0, config_error}, 32'd1);
        checkOutput("t3aDone", {31'b0, done}, 32'd1);
        checkOutput("t3aCycleCount", cycle_count, 32'd2);
        applyStimulus(32'h1000, 32'h2000, 32'd257, 32'd1, 1'b0);
        waitIdle("t3bIdleTimeout");
        checkOutput("t3bConfigError", {31'b0, config_error}, 32'd1);
        checkOutput("t3bDone", {31'b0, done}, 32'd1);
        checkOutput("t3bCycleCount", cycle_count, 32'd2);
        applyStimulus(32'h1000, 32'h2000, 32'd256, 32'd0, 1'b0);
        waitIdle("t3cIdleTimeout");
        checkOutput("t3cConfigError", {31'b0, config_error}, 32'd1);
        checkOutput("t3cDone", {31'b0, done}, 32'd1);
        checkOutput("t3cCycleCount", cycle_count, 32'd2);
        checkOutput("t3NoEnable", riseCount - base, 32'd0);

        $display("[TB] abort during burst 2");
        base = riseCount;
        applyStimulus(32'h0, 32'h100, 32'd8, 32'd5, 1'b0);
        checkOutput("t4ConfigErrorCleared", {31'b0, config_error}, 32'd0);
        waitRises(base + 2, "t4RiseTimeout");
        repeat (3) @(negedge aclk);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        checkOutput("t4EnableHeld", {31'b0, enable}, 32'd1);
        waitIdle("t4IdleTimeout");
        checkOutput("t4Done", {31'b0, done}, 32'd1);
        checkOutput("t4Aborted", {31'b0, aborted}, 32'd1);
        checkOutput("t4BurstsDone", bursts_done, 32'd2);
        checkOutput("t4Rises", riseCount - base, 32'd2);

        $display("[TB] address wrap and held start");
        rdLog.delete();
        wrLog.delete();
        applyStimulus(32'hFFFF_FFF0, 32'h10, 32'd4, 32'd2, 1'b1);
        checkOutput("t5AbortedCleared", {31'b0, aborted}, 32'd0);
        checkOutput("t5DoneCleared", {31'b0, done}, 32'd0);
        waitIdle("t5IdleTimeout");
        while (rdLog.size() < 2) rdLog.push_back(32'hDEAD_BEEF);
        while (wrLog.size() < 2) wrLog.push_back(32'hDEAD_BEEF);
        checkOutput("t5ReadAddr0", rdLog[0], 32'hFFFF_FFF0);
        checkOutput("t5ReadAddrWrap", rdLog[1], 32'h0000_0000);
        checkOutput("t5WriteAddr1", wrLog[1], 32'h20);
        checkOutput("t5BurstsDone", bursts_done, 32'd2);
        base = riseCount;
        repeat (20) @(negedge aclk);
        checkOutput("t5HeldStartBusy", {31'b0, busy}, 32'd0);
        checkOutput("t5HeldStartDone", {31'b0, done}, 32'd1);
        checkOutput("t5HeldStartRises", riseCount - base, 32'd0);
        start = 1'b0;

        $display("[TB] reset mid-burst");
        base = riseCount;
        applyStimulus(32'h4000, 32'h5000, 32'd8, 32'd3, 1'b0);
        waitRises(base + 1, "t6RiseTimeout");
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        checkOutput("t6Enable", {31'b0, enable}, 32'd0);
        checkOutput("t6Busy", {31'b0, busy}, 32'd0);
        checkOutput("t6Done", {31'b0, done}, 32'd0);
        checkOutput("t6BurstsDone", bursts_done, 32'd0);
        checkOutput("t6CycleCount", cycle_count, 32'd0);
        checkOutput("t6ReadAddr", read_address_con, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        applyStimulus(32'h100, 32'h200, 32'd2, 32'd1, 1'b0);
        waitIdle("t6IdleTimeout");
        checkOutput("t6FreshDone", {31'b0, done}, 32'd1);
        checkOutput("t6FreshBurstsDone", bursts_done, 32'd1);
        checkOutput("t6FreshReadAddr", read_address_con, 32'h100);
        checkOutput("t6FreshAborted", {31'b0, aborted}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
